// File: rtl/pattern_lut_cclut_pipe.sv
// ============================================================================
// Module  : pattern_lut_cclut_pipe
// Purpose : Three-stage pipelined CCLUT lookup for NCLCT CLCT candidates per BX,
//           with run-time LUT reload, key edge saturation and invalid-pid flag.
//           Optional macro CCLUT_QUALITY_EN widens LUT words to 18 bits (quality).
//           LUT tables have no power-up contents; load them through the lut_w* port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pattern_lut_cclut_pipe #(
  parameter int NCLCT   = 2,
  parameter int NPID    = 5,
  parameter int MXPIDB  = 4,
  parameter int MXKEYB  = 8,
  parameter int MXPATC  = 12,
  parameter int KEY_MAX = 223,
`ifdef CCLUT_QUALITY_EN
  localparam int MXDATB = 18
`else
  localparam int MXDATB = 9
`endif
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NCLCT-1:0]             vld_in,
  input  logic [NCLCT*MXKEYB-1:0]      key_in,
  input  logic [NCLCT*MXPIDB-1:0]      pid_in,
  input  logic [NCLCT*MXPATC-1:0]      carry_in,
  input  logic                         lut_we,
  input  logic [MXPIDB-1:0]            lut_wpid,
  input  logic [MXPATC-1:0]            lut_wadr,
  input  logic [MXDATB-1:0]            lut_wdat,
  output logic [NCLCT-1:0]             vld_out,
  output logic [NCLCT*MXKEYB-1:0]      best_key,
  output logic [NCLCT*(MXKEYB+2)-1:0]  best_subkey,
  output logic [NCLCT*4-1:0]           offs,
  output logic [NCLCT*5-1:0]           bend,
  output logic [NCLCT*9-1:0]           quality,
  output logic [NCLCT-1:0]             edge_clamp,
  output logic [NCLCT-1:0]             pid_err
);

  localparam int DEPTH = NPID << MXPATC;
  localparam int ADRW  = $clog2(DEPTH);
  localparam int SUMW  = MXKEYB + 2;

  localparam logic [MXPIDB-1:0] C_NPID     = MXPIDB'(NPID);
  localparam logic [SUMW-1:0]   C_KEYMAX_S = SUMW'(KEY_MAX);
  localparam logic [MXKEYB-1:0] C_KEYMAX_K = MXKEYB'(KEY_MAX);

  // {pid, adr} concatenation equals pid*2^MXPATC + adr, i.e. the flat table index
  logic            w_we;
  logic [ADRW-1:0] w_widx;
  assign w_we   = lut_we && (lut_wpid < C_NPID);
  assign w_widx = ADRW'({lut_wpid, lut_wadr});

`ifndef CCLUT_QUALITY_EN
  assign quality = '0;
`endif

  for (genvar c = 0; c < NCLCT; c++) begin : g_ch
    logic [MXDATB-1:0] mem [DEPTH];
    logic [MXDATB-1:0] rdat_q;

    logic              vld0_q, vld1_q, vld2_q;
    logic [MXKEYB-1:0] key0_q, key1_q, bkey2_q;
    logic [MXPIDB-1:0] pid0_q;
    logic [MXPATC-1:0] car0_q;
    logic              perr1_q, perr2_q, clamp2_q;
    logic [1:0]        qs2_q;
    logic [3:0]        offs2_q;
    logic [4:0]        bend2_q;

    logic              w_perr0;
    logic [ADRW-1:0]   w_ridx;
    logic [3:0]        w_offs;
    logic [4:0]        w_bend;
    logic [SUMW-1:0]   w_sum;
    logic [1:0]        w_qs;
    logic [MXKEYB-1:0] bkey_d;
    logic [1:0]        qs_d;
    logic              clamp_d;

    assign w_perr0 = pid0_q >= C_NPID;
    assign w_ridx  = w_perr0 ? '0 : ADRW'({pid0_q, car0_q});

    // Read-before-write: a same-edge write to the read entry returns old data
    always_ff @(posedge clock) begin
      if (w_we) begin
        mem[w_widx] <= lut_wdat;
      end
      rdat_q <= mem[w_ridx];
    end

    // Invalid pid substitutes a zero-offset, zero-bend entry
    assign w_offs = perr1_q ? 4'd7 : rdat_q[8:5];
    assign w_bend = perr1_q ? 5'd0 : rdat_q[4:0];
    assign w_sum  = SUMW'(key1_q) + SUMW'(w_offs[3:2]) + SUMW'(w_offs[1] & w_offs[0]) - SUMW'(2);
    assign w_qs   = w_offs[1:0] + 2'd1;

    always_comb begin
      bkey_d  = w_sum[MXKEYB-1:0];
      qs_d    = w_qs;
      clamp_d = 1'b0;
      if (w_sum[SUMW-1]) begin
        bkey_d  = '0;
        qs_d    = 2'd0;
        clamp_d = 1'b1;
      end else if (w_sum > C_KEYMAX_S) begin
        bkey_d  = C_KEYMAX_K;
        qs_d    = 2'd3;
        clamp_d = 1'b1;
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld0_q   <= 1'b0;
        key0_q   <= '0;
        pid0_q   <= '0;
        car0_q   <= '0;
        vld1_q   <= 1'b0;
        key1_q   <= '0;
        perr1_q  <= 1'b0;
        vld2_q   <= 1'b0;
        bkey2_q  <= '0;
        qs2_q    <= '0;
        clamp2_q <= 1'b0;
        perr2_q  <= 1'b0;
        offs2_q  <= '0;
        bend2_q  <= '0;
      end else begin
        vld0_q   <= vld_in[c];
        key0_q   <= key_in[c*MXKEYB +: MXKEYB];
        pid0_q   <= pid_in[c*MXPIDB +: MXPIDB];
        car0_q   <= carry_in[c*MXPATC +: MXPATC];
        vld1_q   <= vld0_q;
        key1_q   <= key0_q;
        perr1_q  <= vld0_q && w_perr0;
        vld2_q   <= vld1_q;
        bkey2_q  <= vld1_q ? bkey_d  : '0;
        qs2_q    <= vld1_q ? qs_d    : '0;
        clamp2_q <= vld1_q && clamp_d;
        perr2_q  <= vld1_q && perr1_q;
        offs2_q  <= vld1_q ? w_offs  : '0;
        bend2_q  <= vld1_q ? w_bend  : '0;
      end
    end

`ifdef CCLUT_QUALITY_EN
    logic [8:0] qual2_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        qual2_q <= '0;
      end else begin
        qual2_q <= (vld1_q && !perr1_q) ? rdat_q[17:9] : '0;
      end
    end
    assign quality[c*9 +: 9] = qual2_q;
`endif

    assign vld_out[c]                          = vld2_q;
    assign best_key[c*MXKEYB +: MXKEYB]        = bkey2_q;
    assign best_subkey[c*(MXKEYB+2) +: MXKEYB+2] = {bkey2_q, qs2_q};
    assign offs[c*4 +: 4]                      = offs2_q;
    assign bend[c*5 +: 5]                      = bend2_q;
    assign edge_clamp[c]                       = clamp2_q;
    assign pid_err[c]                          = perr2_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pattern_lut_cclut_pipe.sv
// ============================================================================
// Module  : tb_pattern_lut_cclut_pipe
// Purpose : Directed self-checking bench for pattern_lut_cclut_pipe (default build).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pattern_lut_cclut_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  vld_in;
  logic [15:0] key_in;
  logic [7:0]  pid_in;
  logic [23:0] carry_in;
  logic        lut_we;
  logic [3:0]  lut_wpid;
  logic [11:0] lut_wadr;
  logic [8:0]  lut_wdat;
  logic [1:0]  vld_out;
  logic [15:0] best_key;
  logic [19:0] best_subkey;
  logic [7:0]  offs;
  logic [9:0]  bend;
  logic [17:0] quality;
  logic [1:0]  edge_clamp;
  logic [1:0]  pid_err;

  int checks   = 0;
  int failures = 0;

  // Hand-computed results of the offset sweep on key=100
  logic [7:0] exp_key [16] = '{8'd98, 8'd98, 8'd98, 8'd99, 8'd99, 8'd99, 8'd99, 8'd100,
                               8'd100, 8'd100, 8'd100, 8'd101, 8'd101, 8'd101, 8'd101, 8'd102};
  logic [1:0] exp_qs  [16] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
                               2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  pattern_lut_cclut_pipe dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .vld_in      (vld_in),
    .key_in      (key_in),
    .pid_in      (pid_in),
    .carry_in    (carry_in),
    .lut_we      (lut_we),
    .lut_wpid    (lut_wpid),
    .lut_wadr    (lut_wadr),
    .lut_wdat    (lut_wdat),
    .vld_out     (vld_out),
    .best_key    (best_key),
    .best_subkey (best_subkey),
    .offs        (offs),
    .bend        (bend),
    .quality     (quality),
    .edge_clamp  (edge_clamp),
    .pid_err     (pid_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic v, input logic [7:0] k,
                        input logic [3:0] p, input logic [11:0] car);
    vld_in[c]          = v;
    key_in[c*8 +: 8]   = k;
    pid_in[c*4 +: 4]   = p;
    carry_in[c*12 +: 12] = car;
  endtask

  task automatic lut_write(input logic [3:0] p, input logic [11:0] a, input logic [8:0] d);
    lut_we   = 1'b1;
    lut_wpid = p;
    lut_wadr = a;
    lut_wdat = d;
    tick();
    lut_we   = 1'b0;
  endtask

  task automatic chk_ch(input string tag, input int c, input logic v, input logic [7:0] k,
                        input logic [1:0] q, input logic cl, input logic [3:0] o,
                        input logic [4:0] b, input logic pe);
    chk($sformatf("%s.ch%0d.vld", tag, c),    32'(vld_out[c]), 32'(v));
    chk($sformatf("%s.ch%0d.key", tag, c),    32'(best_key[c*8 +: 8]), 32'(k));
    chk($sformatf("%s.ch%0d.subkey", tag, c), 32'(best_subkey[c*10 +: 10]), 32'({k, q}));
    chk($sformatf("%s.ch%0d.clamp", tag, c),  32'(edge_clamp[c]), 32'(cl));
    chk($sformatf("%s.ch%0d.offs", tag, c),   32'(offs[c*4 +: 4]), 32'(o));
    chk($sformatf("%s.ch%0d.bend", tag, c),   32'(bend[c*5 +: 5]), 32'(b));
    chk($sformatf("%s.ch%0d.perr", tag, c),   32'(pid_err[c]), 32'(pe));
    chk($sformatf("%s.ch%0d.qual", tag, c),   32'(quality[c*9 +: 9]), 32'd0);
  endtask

  // Present one vector, then idle; results are visible three edges after capture
  task automatic launch_and_wait();
    tick();
    vld_in = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    reset_n  = 1'b0;
    vld_in   = '0;
    key_in   = '0;
    pid_in   = '0;
    carry_in = '0;
    lut_we   = 1'b0;
    lut_wpid = '0;
    lut_wadr = '0;
    lut_wdat = '0;
    tick();
    tick();
    chk_ch("reset", 0, 1'b0, 8'd0, 2'd0, 1'b0, 4'd0, 5'd0, 1'b0);
    chk_ch("reset", 1, 1'b0, 8'd0, 2'd0, 1'b0, 4'd0, 5'd0, 1'b0);
    reset_n = 1'b1;
    tick();

    // LUT load: pid0 addr o -> offset o, bend o+3
    for (int o = 0; o < 16; o++) lut_write(4'd0, 12'(o), {4'(o), 5'(o + 3)});
    lut_write(4'd4, 12'h010, {4'd7, 5'h11});
    lut_write(4'd2, 12'h3A5, {4'd7, 5'd3});

    // Basic lookup, zero offset on both channels
    set_ch(0, 1'b1, 8'd100, 4'd4, 12'h010);
    set_ch(1, 1'b1, 8'd50,  4'd0, 12'h007);
    launch_and_wait();
    chk_ch("basic", 0, 1'b1, 8'd100, 2'd0, 1'b0, 4'd7, 5'h11, 1'b0);
    chk_ch("basic", 1, 1'b1, 8'd50,  2'd0, 1'b0, 4'd7, 5'd10,  1'b0);

    // Streaming offset sweep on ch0; ch1 carries the same sweep on key 60 with bubbles
    for (int t = 0; t < 18; t++) begin
      if (t < 16) begin
        set_ch(0, 1'b1, 8'd100, 4'd0, 12'(t));
        set_ch(1, (t % 2) == 0, 8'd60, 4'd0, 12'(t));
      end else begin
        set_ch(0, 1'b0, 8'd0, 4'd0, 12'd0);
        set_ch(1, 1'b0, 8'd0, 4'd0, 12'd0);
      end
      tick();
      if (t >= 2) begin
        int j;
        j = t - 2;
        chk_ch($sformatf("sweep%0d", j), 0, 1'b1, exp_key[j], exp_qs[j], 1'b0,
               4'(j), 5'(j + 3), 1'b0);
        if ((j % 2) == 0)
          chk_ch($sformatf("sweep%0d", j), 1, 1'b1, 8'(exp_key[j] - 8'd40), exp_qs[j], 1'b0,
                 4'(j), 5'(j + 3), 1'b0);
        else
          chk_ch($sformatf("bubble%0d", j), 1, 1'b0, 8'd0, 2'd0, 1'b0, 4'd0, 5'd0, 1'b0);
      end
    end

    // Edge saturation at both ends of the chamber
    set_ch(0, 1'b1, 8'd1,   4'd0, 12'd0);
    set_ch(1, 1'b1, 8'd223, 4'd0, 12'd15);
    launch_and_wait();
    chk_ch("sat_lo", 0, 1'b1, 8'd0,   2'd0, 1'b1, 4'd0,  5'd3,  1'b0);
    chk_ch("sat_hi", 1, 1'b1, 8'd223, 2'd3, 1'b1, 4'd15, 5'd18, 1'b0);

    // LUT reload: write lands on the same edge as the read of that entry
    set_ch(0, 1'b1, 8'd80, 4'd2, 12'h3A5);
    set_ch(1, 1'b0, 8'd0,  4'd0, 12'd0);
    tick();
    vld_in   = 2'b00;
    lut_we   = 1'b1;
    lut_wpid = 4'd2;
    lut_wadr = 12'h3A5;
    lut_wdat = {4'd11, 5'd9};
    tick();
    lut_we = 1'b0;
    tick();
    chk_ch("reload_old", 0, 1'b1, 8'd80, 2'd0, 1'b0, 4'd7, 5'd3, 1'b0);
    set_ch(0, 1'b1, 8'd80, 4'd2, 12'h3A5);
    launch_and_wait();
    chk_ch("reload_new", 0, 1'b1, 8'd81, 2'd0, 1'b0, 4'd11, 5'd9, 1'b0);

    // Invalid pattern ID
    set_ch(0, 1'b1, 8'd120, 4'd7, 12'h123);
    set_ch(1, 1'b1, 8'd30,  4'd0, 12'd11);
    launch_and_wait();
    chk_ch("pid_err", 0, 1'b1, 8'd120, 2'd0, 1'b0, 4'd7, 5'd0, 1'b1);
    chk_ch("pid_ok",  1, 1'b1, 8'd31,  2'd0, 1'b0, 4'd11, 5'd14, 1'b0);

    // Reset mid-stream with three candidates in flight
    set_ch(0, 1'b1, 8'd10, 4'd0, 12'd7);
    set_ch(1, 1'b1, 8'd20, 4'd0, 12'd7);
    tick();
    tick();
    tick();
    chk("inflight.vld", 32'(vld_out), 32'd3);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async.vld", 32'(vld_out), 32'd0);
    chk("rst_async.key", 32'(best_key), 32'd0);
    vld_in = 2'b00;
    tick();
    reset_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk($sformatf("post_rst%0d.vld", t), 32'(vld_out), 32'd0);
    end

    // LUT contents survive reset
    set_ch(0, 1'b1, 8'd90, 4'd2, 12'h3A5);
    set_ch(1, 1'b0, 8'd0,  4'd0, 12'd0);
    launch_and_wait();
    chk_ch("retain", 0, 1'b1, 8'd91, 2'd0, 1'b0, 4'd11, 5'd9, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
